legv8_control_fsm: RTL and testbench

Multi-cycle control unit that sits directly upstream of dataPath_core. It consumes the core's IR_out and status outputs and drives every datapath control input: register select, ALU function, tri-state bus selects, memory strobes, IR/status load and PC function. It sequences FETCH/DECODE/EXECUTE/MEM/BRANCH states for a LEGv8 subset, so the datapath runs programs from RAM without a hand-driven bench.

---
 rtl/legv8_control_fsm.sv | 276 +++++++++++++++++++++++++++
 tb/tb_legv8_control_fsm.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/legv8_control_fsm.sv
// Multi-cycle control FSM for the LEGv8 datapath core.
// Sequences fetch/decode/execute/mem/branch and drives every datapath control input.
module legv8_control_fsm #(
  parameter int unsigned PC_STEP = 4,
  parameter logic [1:0]  SIZE_DW = 2'b11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] IR,
  input  logic [3:0]  status,
  output logic        add_tri_sel,
  output logic [1:0]  data_tri_sel,
  output logic        w_reg,
  output logic        C0,
  output logic        mem_cs,
  output logic        mem_write_en,
  output logic        IR_load,
  output logic        status_load,
  output logic [31:0] k,
  output logic [4:0]  FS,
  output logic [1:0]  PC_FS,
  output logic [1:0]  size,
  output logic [4:0]  SA,
  output logic [4:0]  SB,
  output logic [4:0]  DA,
  output logic        PC_sel,
  output logic        B_Sel,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExecute, StMem, StBranch, StHalt
  } state_e;

  typedef enum logic [3:0] {
    ClsAdd, ClsSub, ClsAnd, ClsOrr, ClsAddi, ClsSubi,
    ClsLdur, ClsStur, ClsB, ClsCbz, ClsHalt, ClsIllegal
  } cls_e;

  typedef struct packed {
    logic        add_tri_sel;
    logic [1:0]  data_tri_sel;
    logic        w_reg;
    logic        c0;
    logic        mem_cs;
    logic        mem_write_en;
    logic        ir_load;
    logic        status_load;
    logic [31:0] k;
    logic [4:0]  fs;
    logic [1:0]  pc_fs;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [4:0]  da;
    logic        b_sel;
    logic        halted;
  } ctrl_t;

  localparam logic [4:0] FsAnd = 5'b00000;
  localparam logic [4:0] FsOrr = 5'b01100;
  localparam logic [4:0] FsAdd = 5'b01000;
  localparam logic [4:0] FsSub = 5'b01001;

  state_e      state_q, state_d;
  cls_e        cls_q, cls_d, dec_cls;
  logic [4:0]  rt_q, rt_d, rn_q, rn_d, rm_q, rm_d;
  logic [31:0] k_q, k_d, dec_k;
  logic        illegal_q, illegal_d;
  logic [4:0]  alu_fs;
  ctrl_t       ctrl_q, ctrl_d;
  logic        unused_status;

  always_comb begin
    dec_cls = ClsIllegal;
    dec_k   = '0;
    if (IR == 32'hFFFF_FFFF) begin
      dec_cls = ClsHalt;
    end else if (IR[31:21] == 11'b10001011000) begin
      dec_cls = ClsAdd;
    end else if (IR[31:21] == 11'b11001011000) begin
      dec_cls = ClsSub;
    end else if (IR[31:21] == 11'b10001010000) begin
      dec_cls = ClsAnd;
    end else if (IR[31:21] == 11'b10101010000) begin
      dec_cls = ClsOrr;
    end else if (IR[31:22] == 10'b1001000100) begin
      dec_cls = ClsAddi;
      dec_k   = {20'b0, IR[21:10]};
    end else if (IR[31:22] == 10'b1101000100) begin
      dec_cls = ClsSubi;
      dec_k   = {20'b0, IR[21:10]};
    end else if (IR[31:21] == 11'b11111000010) begin
      dec_cls = ClsLdur;
      dec_k   = {{23{IR[20]}}, IR[20:12]};
    end else if (IR[31:21] == 11'b11111000000) begin
      dec_cls = ClsStur;
      dec_k   = {{23{IR[20]}}, IR[20:12]};
    end else if (IR[31:26] == 6'b000101) begin
      dec_cls = ClsB;
      // The PC was already stepped during fetch, so back that step out of the offset.
      dec_k   = {{4{IR[25]}}, IR[25:0], 2'b00} - 32'(PC_STEP);
    end else if (IR[31:24] == 8'b10110100) begin
      dec_cls = ClsCbz;
      dec_k   = {{11{IR[23]}}, IR[23:5], 2'b00} - 32'(PC_STEP);
    end
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    rt_d      = rt_q;
    rn_d      = rn_q;
    rm_d      = rm_q;
    k_d       = k_q;
    illegal_d = illegal_q;
    case (state_q)
      StIdle:   if (run) state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: begin
        cls_d = dec_cls;
        rt_d  = IR[4:0];
        rn_d  = IR[9:5];
        rm_d  = IR[20:16];
        k_d   = dec_k;
        if (dec_cls == ClsHalt) begin
          state_d = StHalt;
        end else if (dec_cls == ClsIllegal) begin
          illegal_d = 1'b1;
          state_d   = StHalt;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        case (cls_q)
          ClsLdur, ClsStur: state_d = StMem;
          ClsCbz:           state_d = StBranch;
          default:          state_d = StFetch;
        endcase
      end
      StMem, StBranch: state_d = StFetch;
      StHalt:          state_d = StHalt;
      default:         state_d = StIdle;
    endcase
  end

  always_comb begin
    case (cls_d)
      ClsSub, ClsSubi: alu_fs = FsSub;
      ClsAnd:          alu_fs = FsAnd;
      ClsOrr:          alu_fs = FsOrr;
      default:         alu_fs = FsAdd;
    endcase
  end

  // Controls are decoded for the state being entered and registered, so they line up
  // with state_q exactly as a Moore decode would, but come straight from flops.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      StFetch: begin
        ctrl_d.mem_cs       = 1'b1;
        ctrl_d.data_tri_sel = 2'b11;
        ctrl_d.ir_load      = 1'b1;
        ctrl_d.pc_fs        = 2'b01;
      end
      StExecute: begin
        case (cls_d)
          ClsAdd, ClsSub, ClsAnd, ClsOrr: begin
            ctrl_d.sa    = rn_d;
            ctrl_d.sb    = rm_d;
            ctrl_d.da    = rt_d;
            ctrl_d.fs    = alu_fs;
            ctrl_d.c0    = (cls_d == ClsSub);
            ctrl_d.w_reg = 1'b1;
          end
          ClsAddi, ClsSubi: begin
            ctrl_d.sa    = rn_d;
            ctrl_d.da    = rt_d;
            ctrl_d.b_sel = 1'b1;
            ctrl_d.k     = k_d;
            ctrl_d.fs    = alu_fs;
            ctrl_d.c0    = (cls_d == ClsSubi);
            ctrl_d.w_reg = 1'b1;
          end
          ClsLdur, ClsStur: begin
            ctrl_d.sa    = rn_d;
            ctrl_d.b_sel = 1'b1;
            ctrl_d.k     = k_d;
            ctrl_d.fs    = FsAdd;
          end
          ClsB: begin
            ctrl_d.pc_fs = 2'b10;
            ctrl_d.k     = k_d;
          end
          ClsCbz: begin
            ctrl_d.sa          = rt_d;
            ctrl_d.sb          = 5'd31;
            ctrl_d.fs          = FsOrr;
            ctrl_d.status_load = 1'b1;
            ctrl_d.k           = k_d;
          end
          default: ;
        endcase
      end
      StMem: begin
        ctrl_d.add_tri_sel = 1'b1;
        ctrl_d.mem_cs      = 1'b1;
        ctrl_d.sa          = rn_d;
        ctrl_d.b_sel       = 1'b1;
        ctrl_d.k           = k_d;
        ctrl_d.fs          = FsAdd;
        if (cls_d == ClsLdur) begin
          ctrl_d.data_tri_sel = 2'b11;
          ctrl_d.da           = rt_d;
          ctrl_d.w_reg        = 1'b1;
        end else begin
          ctrl_d.sb           = rt_d;
          ctrl_d.data_tri_sel = 2'b01;
          ctrl_d.mem_write_en = 1'b1;
        end
      end
      StBranch: ctrl_d.k      = k_d;
      StHalt:   ctrl_d.halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cls_q     <= ClsAdd;
      rt_q      <= '0;
      rn_q      <= '0;
      rm_q      <= '0;
      k_q       <= '0;
      illegal_q <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      rt_q      <= rt_d;
      rn_q      <= rn_d;
      rm_q      <= rm_d;
      k_q       <= k_d;
      illegal_q <= illegal_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign add_tri_sel  = ctrl_q.add_tri_sel;
  assign data_tri_sel = ctrl_q.data_tri_sel;
  assign w_reg        = ctrl_q.w_reg;
  assign C0           = ctrl_q.c0;
  assign mem_cs       = ctrl_q.mem_cs;
  assign mem_write_en = ctrl_q.mem_write_en;
  assign IR_load      = ctrl_q.ir_load;
  assign status_load  = ctrl_q.status_load;
  assign k            = ctrl_q.k;
  assign FS           = ctrl_q.fs;
  // BRANCH resolves on the Z flag captured during EXECUTE, read live.
  assign PC_FS        = (state_q == StBranch) ? {status[0], 1'b0} : ctrl_q.pc_fs;
  assign size         = SIZE_DW;
  assign SA           = ctrl_q.sa;
  assign SB           = ctrl_q.sb;
  assign DA           = ctrl_q.da;
  assign PC_sel       = 1'b0;
  assign B_Sel        = ctrl_q.b_sel;
  assign halted       = ctrl_q.halted;
  assign illegal      = illegal_q;

  assign unused_status = ^status[3:1];

endmodule

// File: tb/tb_legv8_control_fsm.sv
// Directed bench for legv8_control_fsm: expectations are queued per step and
// popped/compared one cycle later, 1 time unit after the rising edge.
module tb_legv8_control_fsm;

  logic        clock = 1'b0;
  logic        reset, run;
  logic [31:0] IR;
  logic [3:0]  status;
  logic        add_tri_sel, w_reg, C0, mem_cs, mem_write_en, IR_load, status_load;
  logic        PC_sel, B_Sel, halted, illegal;
  logic [1:0]  data_tri_sel, PC_FS, size;
  logic [31:0] k;
  logic [4:0]  FS, SA, SB, DA;

  legv8_control_fsm dut (
    .clock(clock), .reset(reset), .run(run), .IR(IR), .status(status),
    .add_tri_sel(add_tri_sel), .data_tri_sel(data_tri_sel), .w_reg(w_reg), .C0(C0),
    .mem_cs(mem_cs), .mem_write_en(mem_write_en), .IR_load(IR_load),
    .status_load(status_load), .k(k), .FS(FS), .PC_FS(PC_FS), .size(size), .SA(SA),
    .SB(SB), .DA(DA), .PC_sel(PC_sel), .B_Sel(B_Sel), .halted(halted), .illegal(illegal)
  );

  always #5 clock = ~clock;

  typedef enum {
    FAddTri, FDataTri, FWreg, FC0, FMemCs, FMemWe, FIrLoad, FStLoad, FK, FFs, FPcFs,
    FSize, FSa, FSb, FDa, FPcSel, FBSel, FHalted, FIllegal
  } fld_e;

  typedef struct {
    string       tag;
    fld_e        fld;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] get_field(fld_e f);
    case (f)
      FAddTri:  return 32'(add_tri_sel);
      FDataTri: return 32'(data_tri_sel);
      FWreg:    return 32'(w_reg);
      FC0:      return 32'(C0);
      FMemCs:   return 32'(mem_cs);
      FMemWe:   return 32'(mem_write_en);
      FIrLoad:  return 32'(IR_load);
      FStLoad:  return 32'(status_load);
      FK:       return k;
      FFs:      return 32'(FS);
      FPcFs:    return 32'(PC_FS);
      FSize:    return 32'(size);
      FSa:      return 32'(SA);
      FSb:      return 32'(SB);
      FDa:      return 32'(DA);
      FPcSel:   return 32'(PC_sel);
      FBSel:    return 32'(B_Sel);
      FHalted:  return 32'(halted);
      default:  return 32'(illegal);
    endcase
  endfunction

  task automatic push(string tag, fld_e f, logic [31:0] v);
    exp_t e;
    e.tag = tag; e.fld = f; e.value = v;
    sb.push_back(e);
  endtask

  // Advance one clock and check everything queued for the new cycle.
  task automatic step();
    exp_t        e;
    logic [31:0] obs;
    @(posedge clock);
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = get_field(e.fld);
      n_assert++;
      assert (obs === e.value) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.value);
      end
    end
  endtask

  task automatic exp_fetch(string tag);
    push({tag, ".ir_load"}, FIrLoad, 1);
    push({tag, ".pc_fs"}, FPcFs, 1);
    push({tag, ".mem_cs"}, FMemCs, 1);
    push({tag, ".data_tri"}, FDataTri, 3);
    push({tag, ".add_tri"}, FAddTri, 0);
  endtask

  task automatic exp_decode(string tag);
    push({tag, ".ir_load"}, FIrLoad, 0);
    push({tag, ".mem_cs"}, FMemCs, 0);
    push({tag, ".w_reg"}, FWreg, 0);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; IR = '0; status = '0;
    step();
    push("rst.w_reg", FWreg, 0);   push("rst.mem_cs", FMemCs, 0);
    push("rst.pc_fs", FPcFs, 0);   push("rst.k", FK, 0);
    push("rst.fs", FFs, 0);        push("rst.halted", FHalted, 0);
    push("rst.illegal", FIllegal, 0); push("rst.ir_load", FIrLoad, 0);
    push("rst.size", FSize, 3);    push("rst.pc_sel", FPcSel, 0);
    step();

    // ADDI X1,X31,#10
    reset = 1'b0; run = 1'b1; IR = 32'h91002BE1;
    exp_fetch("addi.fetch"); step();
    exp_decode("addi.decode"); step();
    push("addi.sa", FSa, 31);  push("addi.bsel", FBSel, 1); push("addi.k", FK, 10);
    push("addi.fs", FFs, 5'b01000); push("addi.da", FDa, 1); push("addi.w_reg", FWreg, 1);
    push("addi.data_tri", FDataTri, 0); push("addi.c0", FC0, 0);
    step();

    // SUB X5,X0,X1; run dropped mid-program must not stop sequencing
    run = 1'b0; IR = 32'hCB010005;
    exp_fetch("sub.fetch"); step();
    exp_decode("sub.decode"); step();
    push("sub.fs", FFs, 5'b01001); push("sub.c0", FC0, 1); push("sub.sa", FSa, 0);
    push("sub.sb", FSb, 1); push("sub.da", FDa, 5); push("sub.bsel", FBSel, 0);
    push("sub.w_reg", FWreg, 1);
    step();

    // STUR X1,[X0,#-8]
    IR = 32'hF81F8001;
    exp_fetch("stur.fetch"); step();
    exp_decode("stur.decode"); step();
    push("stur.ex.fs", FFs, 5'b01000); push("stur.ex.bsel", FBSel, 1);
    push("stur.ex.w_reg", FWreg, 0); push("stur.ex.c0", FC0, 0);
    step();
    push("stur.add_tri", FAddTri, 1); push("stur.k", FK, 32'hFFFF_FFF8);
    push("stur.mem_we", FMemWe, 1); push("stur.sb", FSb, 1);
    push("stur.data_tri", FDataTri, 1); push("stur.w_reg", FWreg, 0);
    push("stur.mem_cs", FMemCs, 1);
    step();

    // CBZ X3,+2 taken
    IR = 32'hB4000043;
    exp_fetch("stur.next_fetch"); step();
    exp_decode("cbz1.decode"); step();
    push("cbz1.st_load", FStLoad, 1); push("cbz1.sa", FSa, 3); push("cbz1.sb", FSb, 31);
    push("cbz1.fs", FFs, 5'b01100); push("cbz1.bsel", FBSel, 0);
    step();
    status = 4'b0001;
    push("cbz1.pc_fs", FPcFs, 2); push("cbz1.k", FK, 4); push("cbz1.st_load", FStLoad, 0);
    step();

    // CBZ X3,+2 not taken
    exp_fetch("cbz0.fetch"); step();
    exp_decode("cbz0.decode"); step();
    push("cbz0.st_load", FStLoad, 1); step();
    status = 4'b0000;
    push("cbz0.pc_fs", FPcFs, 0); push("cbz0.k", FK, 4); step();

    // B +3: three cycles, PC_FS=10 in EXECUTE with k = 12 - 4
    IR = 32'h14000003;
    exp_fetch("b.fetch"); step();
    exp_decode("b.decode"); step();
    push("b.pc_fs", FPcFs, 2); push("b.k", FK, 8); push("b.w_reg", FWreg, 0); step();

    // LDUR X2,[X0,#8] with reset in MEM
    IR = 32'hF8408002;
    exp_fetch("ldur.fetch"); step();
    exp_decode("ldur.decode"); step();
    push("ldur.ex.fs", FFs, 5'b01000); step();
    push("ldur.w_reg", FWreg, 1); push("ldur.da", FDa, 2); push("ldur.data_tri", FDataTri, 3);
    push("ldur.add_tri", FAddTri, 1); push("ldur.k", FK, 8); push("ldur.mem_cs", FMemCs, 1);
    push("ldur.mem_we", FMemWe, 0);
    step();
    reset = 1'b1;
    push("midrst.w_reg", FWreg, 0); push("midrst.mem_cs", FMemCs, 0);
    push("midrst.illegal", FIllegal, 0); push("midrst.ir_load", FIrLoad, 0);
    push("midrst.add_tri", FAddTri, 0);
    step();

    // Undecodable IR: illegal, then HALT holding with run high
    reset = 1'b0; run = 1'b1; IR = 32'h0000_0000;
    exp_fetch("ill.fetch"); step();
    exp_decode("ill.decode"); push("ill.decode.illegal", FIllegal, 0); step();
    push("ill.illegal", FIllegal, 1); push("ill.halted", FHalted, 1); push("ill.mem_cs", FMemCs, 0);
    step();
    for (int i = 0; i < 10; i++) begin
      push("ill.hold.halted", FHalted, 1); push("ill.hold.ir_load", FIrLoad, 0);
      push("ill.hold.illegal", FIllegal, 1);
      step();
    end

    // Reset clears sticky illegal; explicit HALT opcode is not illegal
    reset = 1'b1;
    push("rst2.illegal", FIllegal, 0); push("rst2.halted", FHalted, 0); step();
    reset = 1'b0; IR = 32'hFFFF_FFFF;
    exp_fetch("halt.fetch"); step();
    exp_decode("halt.decode"); step();
    push("halt.halted", FHalted, 1); push("halt.illegal", FIllegal, 0); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
